// File: rtl/fifo_rd_pkg.sv
// Shared types and the read-issue rule for the FIFO read-side packer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_e;

    typedef struct packed {
        logic lo_vld;
        logic rd_pend;
    } hold_t;

    // A read may only be issued if its returning word is guaranteed a slot:
    // either the lo holder, or the output register if the word completes a pair.
    function automatic logic can_issue(input logic lo_vld, input logic rd_pend,
                                       input logic m_valid, input logic m_ready);
        hold_t h;
        h = '{lo_vld: lo_vld, rd_pend: rd_pend};
        case (h)
            2'b00:   return 1'b1;
            2'b01:   return !m_valid;
            2'b10:   return !m_valid || m_ready;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Drains a synchronous FIFO and packs word pairs into double-width beats on a
// valid/ready stream; a flush pushes out a trailing odd word as a padded half beat.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int                    FIFO_WIDTH = 16,
    parameter logic [FIFO_WIDTH-1:0] PAD_VALUE  = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FIFO_WIDTH-1:0]   fifo_data_out,
    input  logic                    fifo_empty,
    input  logic                    fifo_underflow,
    output logic                    fifo_rd_en,
    input  logic                    flush,
    output logic [2*FIFO_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_half,
    output logic                    flush_done,
    output logic                    err_underflow,
    output logic [CNT_WIDTH-1:0]    beat_cnt
);

    state_e                state, state_nxt;
    logic [FIFO_WIDTH-1:0] lo_reg;
    logic                  lo_vld;
    logic                  rd_pend;
    logic                  out_free;
    logic                  emit_load;
    logic                  pair_load;

    assign out_free   = !m_valid || m_ready;
    assign pair_load  = rd_pend && lo_vld;
    assign fifo_rd_en = rst_n && (state == RUN) && !fifo_empty
                        && can_issue(lo_vld, rd_pend, m_valid, m_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // DRAIN waits for the last in-flight word to land before deciding on a half beat.
    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        emit_load  = 1'b0;
        case (state)
            RUN:   if (flush) state_nxt = DRAIN;
            DRAIN: if (!rd_pend) begin
                if (lo_vld) begin
                    state_nxt = EMIT;
                end else begin
                    flush_done = 1'b1;
                    state_nxt  = RUN;
                end
            end
            EMIT:  if (out_free) begin
                emit_load  = 1'b1;
                flush_done = 1'b1;
                state_nxt  = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            lo_reg  <= '0;
            lo_vld  <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en && !fifo_empty;
            if (rd_pend && !lo_vld) begin
                lo_reg <= fifo_data_out;
                lo_vld <= 1'b1;
            end else if (pair_load || emit_load) begin
                lo_vld <= 1'b0;
            end
        end
    end

    // Issue rule guarantees a pair never lands on an unaccepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_half  <= 1'b0;
        end else if (pair_load) begin
            m_data  <= {fifo_data_out, lo_reg};
            m_valid <= 1'b1;
            m_half  <= 1'b0;
        end else if (emit_load) begin
            m_data  <= {PAD_VALUE, lo_reg};
            m_valid <= 1'b1;
            m_half  <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (m_valid && m_ready) beat_cnt <= beat_cnt + 1'b1;
            if (fifo_underflow)     err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO and a beat scoreboard.
module tb_fifo_rd_packer;

    localparam int W = 16;

    typedef struct packed {
        logic [2*W-1:0] data;
        logic           half;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   fifo_data_out = '0;
    logic           fifo_empty = 1'b1;
    logic           fifo_underflow;
    logic           fifo_rd_en;
    logic           flush;
    logic [2*W-1:0] m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_half;
    logic           flush_done;
    logic           err_underflow;
    logic [15:0]    beat_cnt;

    logic           wr_en;
    logic [W-1:0]   wr_data;
    logic [W-1:0]   fq[$];
    beat_t          exp_q[$];

    int total = 0, bad = 0, cyc = 0;
    int fd_cnt = 0, rd_cnt = 0, vld_cnt = 0, first_rd = -1, first_v = -1;

    always #5 clk = ~clk;

    fifo_rd_packer dut (
        .clk(clk), .rst_n(rst_n), .fifo_data_out(fifo_data_out),
        .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_half(m_half),
        .flush_done(flush_done), .err_underflow(err_underflow),
        .beat_cnt(beat_cnt)
    );

    // Synchronous FIFO model: data_out registered one cycle after rd_en.
    always @(posedge clk) begin
        logic [W-1:0] w;
        if (fifo_rd_en && fq.size() > 0) begin
            w = fq.pop_front();
            fifo_data_out <= w;
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, score accepted beats, return just after the edge.
    task automatic step();
        beat_t e;
        @(negedge clk);
        cyc++;
        if (fifo_rd_en) rd_cnt++;
        if (m_valid) vld_cnt++;
        if (flush_done) fd_cnt++;
        if (fifo_rd_en && first_rd < 0) first_rd = cyc;
        if (m_valid && first_v < 0) first_v = cyc;
        chk("rd_en_while_empty", {63'd0, fifo_rd_en & fifo_empty}, 64'd0);
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_beat observed=%0h expected=none", m_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", {32'd0, m_data}, {32'd0, e.data});
                chk("beat_half", {63'd0, m_half}, {63'd0, e.half});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
        m_ready = 1'b0; fifo_underflow = 1'b0;
        #2;
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", {32'd0, m_data}, 64'd0);
        chk("rst_m_half", {63'd0, m_half}, 64'd0);
        chk("rst_flush_done", {63'd0, flush_done}, 64'd0);
        chk("rst_err", {63'd0, err_underflow}, 64'd0);
        chk("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // basic pack and latency
        m_ready = 1'b1;
        exp_q.push_back('{32'h2222_1111, 1'b0});
        wr(16'h1111);
        wr(16'h2222);
        repeat (8) step();
        chk("basic_latency", 64'(first_v - first_rd), 64'd3);
        chk("basic_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("basic_beat_cnt", {48'd0, beat_cnt}, 64'd1);

        // backpressure
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) wr(W'(i));
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{{W'(2*i+2), W'(2*i+1)}, 1'b0});
        repeat (10) step();
        rd_cnt = 0;
        repeat (10) step();
        chk("bp_rd_stalled", 64'(rd_cnt), 64'd0);
        chk("bp_held_valid", {63'd0, m_valid}, 64'd1);
        chk("bp_held_data", {32'd0, m_data}, 64'h0002_0001);
        m_ready = 1'b1;
        repeat (30) step();
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("bp_beat_cnt", {48'd0, beat_cnt}, 64'd5);

        // odd flush
        exp_q.push_back('{32'h00BB_00AA, 1'b0});
        exp_q.push_back('{32'h0000_00CC, 1'b1});
        wr(16'h00AA);
        wr(16'h00BB);
        wr(16'h00CC);
        repeat (10) step();
        chk("odd_one_left", 64'(exp_q.size()), 64'd1);
        fd_cnt = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (6) step();
        chk("odd_flush_done_once", 64'(fd_cnt), 64'd1);
        chk("odd_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("odd_beat_cnt", {48'd0, beat_cnt}, 64'd7);

        // empty flush: pulse exactly one cycle after flush, no beat
        fd_cnt = 0; vld_cnt = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("eflush_not_same_cycle", 64'(fd_cnt), 64'd0);
        chk("eflush_pulse", {63'd0, flush_done}, 64'd1);
        step();
        chk("eflush_pulse_ends", {63'd0, flush_done}, 64'd0);
        repeat (3) step();
        chk("eflush_one_pulse", 64'(fd_cnt), 64'd1);
        chk("eflush_no_beat", 64'(vld_cnt), 64'd0);

        // reset with a held beat and a read in flight
        m_ready = 1'b0;
        wr(16'h0A01);
        wr(16'h0A02);
        wr(16'h0A03);
        for (int i = 0; i < 10 && !m_valid; i++) step();
        chk("rst_pre_valid", {63'd0, m_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("midrst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
        chk("midrst_m_data", {32'd0, m_data}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_ready = 1'b1;
        vld_cnt = 0;
        repeat (10) step();
        chk("midrst_no_beat", 64'(vld_cnt), 64'd0);
        chk("midrst_cnt_after", {48'd0, beat_cnt}, 64'd0);

        // underflow is sticky and does not stop traffic
        fifo_underflow = 1'b1;
        step();
        fifo_underflow = 1'b0;
        chk("uf_set", {63'd0, err_underflow}, 64'd1);
        exp_q.push_back('{32'h5678_1234, 1'b0});
        exp_q.push_back('{32'hDEF0_9ABC, 1'b0});
        wr(16'h1234);
        wr(16'h5678);
        wr(16'h9ABC);
        wr(16'hDEF0);
        repeat (12) step();
        chk("uf_sticky", {63'd0, err_underflow}, 64'd1);
        chk("uf_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("uf_beat_cnt", {48'd0, beat_cnt}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
